mult_unsigned_seq_rc: RTL and testbench



---
 rtl/mult_unsigned_seq_rc.sv | 242 ++++++++++++++++++++++++
 tb/tb_mult_unsigned_seq_rc.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_unsigned_seq_rc.sv
// mult_unsigned_seq_rc
// Iterative unsigned shift-and-add multiplier. Each RUN cycle consumes STEP
// multiplier bits. Operands enter and the product leaves through valid/ready
// handshakes.
// Optional feature macro: MULT_RESIDUE_CHECK_EN. When it is defined, the block
// compares the mod-3 residue of the operands with the mod-3 residue of the final
// accumulator, and flags any mismatch on fault and fault_sticky.
module mult_unsigned_seq_rc #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 fault,
    output logic                 fault_sticky
);

    localparam int PW     = 2 * WIDTH;
    localparam int NSTEPS = WIDTH / STEP;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int SW     = CW + 3;
    localparam logic [CW-1:0] LAST_COUNT = CW'(NSTEPS - 1);

    // Reject illegal configurations at elaboration time.
    if ((WIDTH < 2) || (WIDTH > 32) ||
        !((STEP == 1) || (STEP == 2) || (STEP == 4)) ||
        ((WIDTH % STEP) != 0)) begin : g_bad_params
        $error("mult_unsigned_seq_rc: illegal WIDTH/STEP combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  mcand_reg;
    logic [WIDTH-1:0]  mplier_reg;
    logic [PW-1:0]     acc_reg;
    logic [CW-1:0]     count_reg;
    logic [PW-1:0]     p_reg;

    logic              accept;
    logic              last_step;
    logic [PW-1:0]     pp_row [STEP];
    logic [PW-1:0]     pp_sum;
    logic [SW-1:0]     shamt;
    logic [PW-1:0]     acc_sum;

    // ------------------------------------------------------------------
    // Datapath: partial product of this step, aligned and added to acc
    // ------------------------------------------------------------------

    // One row per multiplier bit consumed this cycle: mcand gated by that bit
    // and shifted by its position inside the step.
    for (genvar gi = 0; gi < STEP; gi++) begin : g_row
        assign pp_row[gi] = mplier_reg[gi] ? (PW'(mcand_reg) << gi) : '0;
    end

    // Sum the rows to get mcand * mplier[STEP-1:0].
    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < STEP; i++) begin
            pp_sum = pp_sum + pp_row[i];
        end
    end

    // The full-width adder cannot overflow: the largest result, (2^W-1)^2,
    // fits in 2*W bits.
    assign shamt     = SW'(count_reg) * SW'(STEP);
    assign acc_sum   = acc_reg + (pp_sum << shamt);
    assign accept    = in_valid && (state_reg == S_IDLE);
    assign last_step = (count_reg == LAST_COUNT);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs. There is no early exit: every
    // product takes exactly NSTEPS RUN cycles.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, accumulator and product registers
    // ------------------------------------------------------------------

    // Capture operands on acceptance; shift the multiplier out STEP bits per
    // RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (accept) begin
            mcand_reg  <= a;
            mplier_reg <= b;
        end else if (state_reg == S_RUN) begin
            mplier_reg <= mplier_reg >> STEP;
        end
    end

    // Clear acc and count on acceptance; accumulate once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (accept) begin
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (state_reg == S_RUN) begin
            acc_reg   <= acc_sum;
            count_reg <= count_reg + 1'b1;
        end
    end

    // The product register is loaded only on RUN->DONE. It keeps the last
    // result after the transfer, until the next product replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg <= '0;
        end else if ((state_reg == S_RUN) && last_step) begin
            p_reg <= acc_sum;
        end
    end

    assign p = p_reg;

    // ------------------------------------------------------------------
    // Optional mod-3 residue checker
    // ------------------------------------------------------------------
`ifdef MULT_RESIDUE_CHECK_EN

    logic [1:0] ra_reg;
    logic [1:0] rb_reg;
    logic       fault_reg;
    logic       sticky_reg;
    logic [1:0] acc_res;
    logic [1:0] exp_res;
    logic       mismatch;

    // Bit-serial mod-3 reduction, MSB first: r = (2*r + bit) mod 3.
    function automatic logic [1:0] mod3(input logic [PW-1:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = PW - 1; i >= 0; i--) begin
            case ({r, v[i]})
                3'b000:  r = 2'd0;
                3'b001:  r = 2'd1;
                3'b010:  r = 2'd2;
                3'b011:  r = 2'd0;
                3'b100:  r = 2'd1;
                3'b101:  r = 2'd2;
                default: r = 2'd0;
            endcase
        end
        return r;
    endfunction

    // The accumulator residue comes from the final sum itself rather than
    // from a running residue. A flipped acc bit therefore shows up as a
    // mismatch.
    assign acc_res  = mod3(acc_sum);
    assign exp_res  = mod3(PW'({2'b00, ra_reg} * {2'b00, rb_reg}));
    assign mismatch = (acc_res != exp_res);

    // Operand residues are captured at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_reg <= 2'd0;
            rb_reg <= 2'd0;
        end else if (accept) begin
            ra_reg <= mod3(PW'(a));
            rb_reg <= mod3(PW'(b));
        end
    end

    // fault is registered together with p. The sticky flag is cleared only
    // by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_reg  <= 1'b0;
            sticky_reg <= 1'b0;
        end else if ((state_reg == S_RUN) && last_step) begin
            fault_reg  <= mismatch;
            sticky_reg <= sticky_reg | mismatch;
        end
    end

    assign fault        = fault_reg;
    assign fault_sticky = sticky_reg;

`else

    assign fault        = 1'b0;
    assign fault_sticky = 1'b0;

`endif

endmodule

// File: tb/tb_mult_unsigned_seq_rc.sv
// Scoreboard bench for mult_unsigned_seq_rc. A 4-bit/STEP=1 instance and an
// 8-bit/STEP=2 instance share the clock and reset. Stimulus pushes the expected
// products; per-instance monitors pop and compare on every output transfer.
module tb_mult_unsigned_seq_rc;

`ifdef MULT_RESIDUE_CHECK_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] p;
        bit          corrupt;
        bit          fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic [7:0]  p4;
    logic        fault4;
    logic        sticky4;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [15:0] p8;
    logic        fault8;
    logic        sticky8;

    exp_t        q4[$];
    exp_t        q8[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          rdy_mode = 0;   // 0: out_ready4 high, 1: random, 2: manual
    bit          sticky4_exp = 1'b0;
    bit          sticky8_exp = 1'b0;

    mult_unsigned_seq_rc #(.WIDTH(4), .STEP(1)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4), .p(p4),
        .fault(fault4), .fault_sticky(sticky4)
    );

    mult_unsigned_seq_rc #(.WIDTH(8), .STEP(2)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .p(p8),
        .fault(fault8), .fault_sticky(sticky8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present operands to the 4-bit instance and wait for acceptance.
    // Returns 1 time unit after the accepting edge.
    task automatic send4(input logic [3:0] aa, input logic [3:0] bb,
                         input bit push, input bit corrupt);
        exp_t e;
        bit   hs;
        bit   done;
        done = 1'b0;
        in_valid4 = 1'b1;
        a4 = aa;
        b4 = bb;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            hs = in_ready4;
            @(posedge clk);
            if (hs) done = 1'b1;
        end
        if (!done) check("dut4_accept_timeout", 0, 1);
        if (push) begin
            e.p = 16'(aa) * 16'(bb);
            e.corrupt = corrupt;
            e.fault = corrupt && RC_EN;
            q4.push_back(e);
        end
        #1;
        in_valid4 = 1'b0;
    endtask

    // Present operands to the 8-bit instance and wait for acceptance.
    task automatic send8(input logic [7:0] aa, input logic [7:0] bb, input logic [15:0] expp);
        exp_t e;
        bit   hs;
        bit   done;
        done = 1'b0;
        in_valid8 = 1'b1;
        a8 = aa;
        b8 = bb;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            hs = in_ready8;
            @(posedge clk);
            if (hs) done = 1'b1;
        end
        if (!done) check("dut8_accept_timeout", 0, 1);
        e.p = expp;
        e.corrupt = 1'b0;
        e.fault = 1'b0;
        q8.push_back(e);
        #1;
        in_valid8 = 1'b0;
    endtask

    // Drive out_ready4 according to the current mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready4 = 1'b1;
            else if (rdy_mode == 1) out_ready4 = 1'($urandom_range(0, 1));
        end
    end

    // Monitor for the 4-bit instance: compare each transferred product.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst_n) begin
            sticky4_exp = 1'b0;
        end else if (out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                check("dut4_unexpected_product", 32'(p4), 32'hFFFF_FFFF);
            end else begin
                e = q4.pop_front();
                sticky4_exp = sticky4_exp | e.fault;
                if (e.corrupt) begin
                    n_tests++;
                    if (p4 == e.p[7:0]) begin
                        n_fail++;
                        $display("FAIL dut4_corrupt_p: got %0d, required a value other than %0d", p4, e.p);
                    end
                end else begin
                    check("dut4_p", 32'(p4), 32'(e.p));
                end
                check("dut4_fault", 32'(fault4), 32'(e.fault));
                check("dut4_fault_sticky", 32'(sticky4), 32'(sticky4_exp));
                $display("[TB] dut4 product p=%0d fault=%0d sticky=%0d", p4, fault4, sticky4);
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst_n) begin
            sticky8_exp = 1'b0;
        end else if (out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                check("dut8_unexpected_product", 32'(p8), 32'hFFFF_FFFF);
            end else begin
                e = q8.pop_front();
                check("dut8_p", 32'(p8), 32'(e.p));
                check("dut8_fault", 32'(fault8), 32'(e.fault));
                check("dut8_fault_sticky", 32'(sticky8), 32'(sticky8_exp));
                $display("[TB] dut8 product p=%0d fault=%0d", p8, fault8);
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        #12;
        check("rst_out_valid", 32'(out_valid4), 0);
        check("rst_p", 32'(p4), 0);
        check("rst_fault", 32'(fault4), 0);
        check("rst_fault_sticky", 32'(sticky4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready4), 1);

        // 15*15 with the latency and post-transfer in_ready checks.
        send4(4'd15, 4'd15, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat4_out_valid_edge%0d", i), 32'(out_valid4), 32'(i == 4));
        end
        check("lat4_p_225", 32'(p4), 225);
        @(posedge clk);
        #1;
        check("post_xfer_in_ready", 32'(in_ready4), 1);
        check("post_xfer_out_valid", 32'(out_valid4), 0);
        check("post_xfer_p_held", 32'(p4), 225);

        // 8-bit, STEP=2 directed vectors.
        send8(8'd255, 8'd255, 16'd65025);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat8_out_valid_edge%0d", i), 32'(out_valid8), 32'(i == 4));
        end
        @(posedge clk);
        #1;
        send8(8'd0, 8'd200, 16'd0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat8z_out_valid_edge%0d", i), 32'(out_valid8), 32'(i == 4));
        end
        send8(8'd200, 8'd3, 16'd600);
        send8(8'd16, 8'd17, 16'd272);

        // Backpressure: product held while a new operand waits.
        rdy_mode = 2;
        out_ready4 = 1'b0;
        send4(4'd6, 4'd7, 1'b1, 1'b0);
        in_valid4 = 1'b1;
        a4 = 4'd2;
        b4 = 4'd9;
        for (int i = 0; i < 20 && !out_valid4; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid4), 1);
            check("bp_in_ready", 32'(in_ready4), 0);
            check("bp_p_42", 32'(p4), 42);
            @(posedge clk);
            #1;
        end
        out_ready4 = 1'b1;
        send4(4'd2, 4'd9, 1'b1, 1'b0);
        rdy_mode = 0;

        // Reset in the middle of RUN, at count=2.
        for (int i = 0; i < 20 && !in_ready4; i++) begin
            @(posedge clk);
            #1;
        end
        send4(4'd9, 4'd11, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 32'(out_valid4), 0);
        check("midrun_rst_p", 32'(p4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_rst_in_ready", 32'(in_ready4), 1);
        send4(4'd3, 4'd5, 1'b1, 1'b0);

        // Accumulator bit flip for 7*9. Only the checking build sees fault=1.
`ifdef MULT_RESIDUE_CHECK_EN
        for (int i = 0; i < 20 && !in_ready4; i++) begin
            @(posedge clk);
            #1;
        end
        send4(4'd7, 4'd9, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        force dut4.acc_reg = 8'd23;
        @(negedge clk);
        release dut4.acc_reg;
`else
        send4(4'd7, 4'd9, 1'b1, 1'b0);
`endif
        send4(4'd4, 4'd4, 1'b1, 1'b0);

        // Exhaustive 4-bit operands with random input gaps and random out_ready.
        rdy_mode = 1;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send4(4'(ia), 4'(ib), 1'b1, 1'b0);
            end
        end
        rdy_mode = 0;

        // Drain both scoreboards.
        for (int i = 0; i < 3000 && (q4.size() != 0 || q8.size() != 0); i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("dut4_drain", 32'(q4.size()), 0);
        check("dut8_drain", 32'(q8.size()), 0);
        check("final_fault_sticky", 32'(sticky4), 32'(RC_EN));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
